// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: producer/consumer handshake and status bundle for sync_fifo_flags
interface sync_fifo_flags_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic              flush;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic              clr_err;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              underflow;
   modport master (
      output flush, wr_en, wr_data, rd_en, clr_err,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
   modport slave (
      input  flush, wr_en, wr_data, rd_en, clr_err,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, thresholds, sticky errors, flush and FWFT/registered read
module sync_fifo_flags #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 1,
   parameter int AW        = $clog2(DEPTH)
) (
   input logic           clk,
   input logic           rst,
   sync_fifo_flags_if.slave bus
);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr, cnt;
   logic              full, empty, wr_acc, rd_acc;
   logic              ovf, unf;
   assign full   = cnt == DEPTH_C;
   assign empty  = cnt == '0;
   assign wr_acc = bus.wr_en & ~full & ~bus.flush;
   assign rd_acc = bus.rd_en & ~empty & ~bus.flush;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = cnt >= AF_C;
   assign bus.almost_empty = cnt <= AE_C;
   assign bus.count        = cnt;
   assign bus.overflow     = ovf;
   assign bus.underflow    = unf;
   // storage; contents are deliberately left unreset
   always_ff @(posedge clk)
      if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
   // pointers and occupancy; flush behaves like a reset of the queue state only
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
      end
   end
   // sticky errors; a new event wins over clr_err, flush-cycle requests are ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         ovf <= (ovf & ~bus.clr_err) | (bus.wr_en & full & ~bus.flush);
         unf <= (unf & ~bus.clr_err) | (bus.rd_en & empty & ~bus.flush);
      end
   end
   generate
      if (FWFT != 0) begin : g_fwft
         assign bus.rd_data  = mem[rd_ptr[AW-1:0]];
         assign bus.rd_valid = ~empty;
      end else begin : g_reg
         logic [DATA_W-1:0] rd_data_q;
         logic              rd_valid_q;
         // registered read: data captured at the pop edge, valid for one cycle
         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_acc;
               if (rd_acc) rd_data_q <= mem[rd_ptr[AW-1:0]];
            end
         end
         assign bus.rd_data  = rd_data_q;
         assign bus.rd_valid = rd_valid_q;
      end
   endgenerate
endmodule
